// File: rtl/player_pose_sequencer_if.sv
// Bus between the per-pose animation units, key/terrain inputs and the
// renderer-facing side of player_pose_sequencer.
interface player_pose_sequencer_if;
   // No valid/ready pair here: frame_tick is a one-Clk strobe that marks the
   // only cycles in which a pose change may be taken. Every other input is
   // level state, sampled on each Clk.
   logic        frame_tick;
   logic [3:0]  keycode;
   logic        on_ground;
   logic [3:0]  unitOn;
   logic [20:0] unitAddr0;
   logic [20:0] unitAddr1;
   logic [20:0] unitAddr2;
   logic [20:0] unitAddr3;
   logic        playerOn;
   logic [20:0] spriteAddress;
   logic [3:0]  anim_sel;
   logic [3:0]  anim_restart;
   logic        moving;
   logic [1:0]  pose;
   logic [5:0]  dwell;

   modport master (
      output frame_tick, keycode, on_ground, unitOn,
             unitAddr0, unitAddr1, unitAddr2, unitAddr3,
      input  playerOn, spriteAddress, anim_sel, anim_restart, moving, pose, dwell
   );

   modport slave (
      input  frame_tick, keycode, on_ground, unitOn,
             unitAddr0, unitAddr1, unitAddr2, unitAddr3,
      output playerOn, spriteAddress, anim_sel, anim_restart, moving, pose, dwell
   );
endinterface

// File: rtl/player_pose_sequencer.sv
// Picks which animation unit (stand/run/prone/jump) feeds the sprite path,
// changing pose only on frame boundaries with dwell-based hysteresis.
module player_pose_sequencer #(
   parameter logic [3:0] KEY_RIGHT       = 4'h1,
   parameter logic [3:0] KEY_LEFT        = 4'h2,
   parameter logic [3:0] KEY_JUMP        = 4'h3,
   parameter logic [3:0] KEY_DOWN_R      = 4'h7,
   parameter logic [3:0] KEY_DOWN_L      = 4'h8,
   parameter logic [5:0] HOLD_FRAMES     = 6'd2,
   parameter logic [5:0] JUMP_MIN_FRAMES = 6'd8
) (
   input  logic                    Clk,
   input  logic                    Reset,
   player_pose_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      STAND = 2'd0,
      RUN   = 2'd1,
      PRONE = 2'd2,
      JUMP  = 2'd3
   } pose_t;

   pose_t       poseReg;
   pose_t       nextPose;
   logic [5:0]  dwell;
   logic [3:0]  restartReg;
   logic        playerOnReg;
   logic [20:0] spriteAddrReg;
   logic [20:0] selAddr;
   logic        wantRun;
   logic        wantProne;
   logic        wantJump;

   assign wantRun   = (bus.keycode == KEY_RIGHT)  || (bus.keycode == KEY_LEFT);
   assign wantProne = (bus.keycode == KEY_DOWN_R) || (bus.keycode == KEY_DOWN_L);
   assign wantJump  = (bus.keycode == KEY_JUMP);

   // Falling off terrain outranks everything; keys are ignored mid-air.
   always_comb begin
      nextPose = poseReg;
      if (poseReg != JUMP && !bus.on_ground) begin
         nextPose = JUMP;
      end else if ((poseReg == STAND || poseReg == RUN) && wantJump && bus.on_ground) begin
         nextPose = JUMP;
      end else if (poseReg == JUMP) begin
         if (bus.on_ground && dwell >= JUMP_MIN_FRAMES) begin
            nextPose = STAND;
         end
      end else if (dwell >= HOLD_FRAMES) begin
         if (wantProne) begin
            nextPose = PRONE;
         end else if (wantRun) begin
            nextPose = RUN;
         end else begin
            nextPose = STAND;
         end
      end
   end

   always_comb begin
      selAddr = bus.unitAddr0;
      case (poseReg)
         STAND: selAddr = bus.unitAddr0;
         RUN:   selAddr = bus.unitAddr1;
         PRONE: selAddr = bus.unitAddr2;
         JUMP:  selAddr = bus.unitAddr3;
         default: selAddr = bus.unitAddr0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         poseReg       <= STAND;
         dwell         <= 6'd0;
         restartReg    <= 4'b0001;
         playerOnReg   <= 1'b0;
         spriteAddrReg <= 21'd0;
      end else begin
         restartReg    <= 4'b0000;
         playerOnReg   <= bus.unitOn[poseReg];
         spriteAddrReg <= selAddr;
         if (bus.frame_tick) begin
            if (nextPose != poseReg) begin
               poseReg    <= nextPose;
               dwell      <= 6'd0;
               restartReg <= 4'b0001 << nextPose;
            end else if (dwell != 6'd63) begin
               dwell <= dwell + 6'd1;
            end
         end
      end
   end

   assign bus.pose          = poseReg;
   assign bus.dwell         = dwell;
   assign bus.anim_sel      = 4'b0001 << poseReg;
   assign bus.anim_restart  = restartReg;
   assign bus.moving        = (poseReg == RUN) || (poseReg == JUMP);
   assign bus.playerOn      = playerOnReg;
   assign bus.spriteAddress = spriteAddrReg;

endmodule
